// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared error codes and FSM encoding for the APB interconnect
package apb_pkg;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_UNMAP = 2'd1;
    localparam logic [1:0] ERR_TMO   = 2'd2;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_watchdog.sv
// rtl/apb_watchdog.sv - per-transfer access-phase wait counter with expiry flag
module apb_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    output logic expire
);

    if (TIMEOUT > 0) begin : g_wdt
        localparam int CW = $clog2(TIMEOUT + 1);

        logic [CW-1:0] cnt;

        // Saturating count of wait cycles in the current access phase.
        always_ff @(posedge clk) begin
            if (rst || !active) begin
                cnt <= '0;
            end else if (!ready && (cnt != CW'(TIMEOUT))) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign expire = active && !ready && (cnt == CW'(TIMEOUT - 1));
    end else begin : g_no_wdt
        logic unused_wdt;
        assign unused_wdt = &{1'b0, clk, rst, active, ready};
        assign expire     = 1'b0;
    end

endmodule

// File: rtl/apbbus_wdt.sv
// rtl/apbbus_wdt.sv - APB3 one-to-N interconnect with unmapped/timeout error responses and capture
module apbbus_wdt
    import apb_pkg::*;
#(
    parameter int          N        = 4,
    parameter int          DEC_LSB  = 16,
    parameter int          TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = 32'hdeadbeef
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            up_psel,
    input  logic            up_penable,
    input  logic            up_pwrite,
    input  logic [31:0]     up_paddr,
    input  logic [31:0]     up_pwdata,
    output logic            up_pready,
    output logic [31:0]     up_prdata,
    output logic            up_pslverr,
    output logic [N-1:0]    down_psel_vec,
    output logic            down_penable,
    output logic            down_pwrite,
    output logic [31:0]     down_paddr,
    output logic [31:0]     down_pwdata,
    input  logic [N-1:0]    down_pready_vec,
    input  logic [N-1:0]    down_pslverr_vec,
    input  logic [N*32-1:0] down_prdata_vec,
    output logic            err_valid,
    output logic [1:0]      err_code,
    output logic [31:0]     err_addr,
    output logic            err_ovf,
    input  logic            err_clr
);

    localparam int SELW = (N > 1) ? $clog2(N) : 1;

    apb_state_t    state, state_nxt;
    logic [SELW-1:0] idx;
    logic          mapped;
    logic          sel_ready;
    logic          sel_slverr;
    logic [31:0]   sel_rdata;
    logic          in_access;
    logic          wdt_ready;
    logic          expire;
    logic          err_evt;
    logic [1:0]    err_evt_code;

    assign idx    = up_paddr[DEC_LSB +: SELW];
    assign mapped = (32'(idx) < N);

    assign down_penable = up_penable;
    assign down_pwrite  = up_pwrite;
    assign down_paddr   = up_paddr;
    assign down_pwdata  = up_pwdata;

    always_comb begin
        down_psel_vec = '0;
        sel_ready     = 1'b0;
        sel_slverr    = 1'b0;
        sel_rdata     = '0;
        for (int i = 0; i < N; i++) begin
            if (32'(idx) == i) begin
                down_psel_vec[i] = up_psel && !rst;
                sel_ready        = down_pready_vec[i];
                sel_slverr       = down_pslverr_vec[i];
                sel_rdata        = down_prdata_vec[i*32 +: 32];
            end
        end
    end

    // Only the first access cycle onward counts; a stray penable while IDLE does not arm the watchdog.
    assign in_access = !rst && up_psel && up_penable && (state != APB_IDLE);
    assign wdt_ready = mapped ? sel_ready : 1'b1;

    apb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk    (clk),
        .rst    (rst),
        .active (in_access),
        .ready  (wdt_ready),
        .expire (expire)
    );

    always_comb begin
        up_pready  = 1'b1;
        up_pslverr = 1'b0;
        up_prdata  = ERR_DATA;
        if (!rst && up_psel) begin
            if (!mapped) begin
                up_pslverr = up_penable;
            end else if (expire) begin
                up_pslverr = 1'b1;
            end else begin
                up_pready  = sel_ready;
                up_pslverr = sel_slverr;
                up_prdata  = sel_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            APB_IDLE: begin
                if (up_psel && !up_penable) state_nxt = APB_SETUP;
            end
            APB_SETUP: begin
                if (!up_psel)       state_nxt = APB_IDLE;
                else if (up_penable) state_nxt = up_pready ? APB_IDLE : APB_ACCESS;
            end
            APB_ACCESS: begin
                if (!up_psel)        state_nxt = APB_IDLE;
                else if (!up_penable) state_nxt = APB_SETUP;
                else if (up_pready)   state_nxt = APB_IDLE;
            end
            default: state_nxt = APB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= APB_IDLE;
        else     state <= state_nxt;
    end

    assign err_evt      = !rst && up_psel && up_penable && (!mapped || expire);
    assign err_evt_code = mapped ? ERR_TMO : ERR_UNMAP;

    // A fresh error beats a coincident clear and restarts the record without overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            err_addr  <= '0;
            err_ovf   <= 1'b0;
        end else if (err_evt) begin
            if (err_valid && !err_clr) begin
                err_ovf <= 1'b1;
            end else begin
                err_valid <= 1'b1;
                err_code  <= err_evt_code;
                err_addr  <= up_paddr;
                err_ovf   <= 1'b0;
            end
        end else if (err_clr) begin
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            err_addr  <= '0;
            err_ovf   <= 1'b0;
        end
    end

endmodule
